// File: rtl/muldiv_seq.sv
// Sequential 32x32 unsigned multiply / divide unit, one bit per cycle, borrowing a shared ALU.
// Divide is built only when MULDIV_SEQ_DIV_EN is defined; otherwise op=1 completes at once with zero results.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_w
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;    // multiply accumulator / divide remainder
  logic [31:0] r_lo;    // multiplier shifting out / quotient shifting in
  logic [31:0] r_b;     // multiplicand / divisor
  logic        r_busy;
  logic        r_done;

  logic        w_carry;
  logic [31:0] w_nxt_hi;
  logic [31:0] w_nxt_lo;

`ifdef MULDIV_SEQ_DIV_EN
  logic        r_op;
  logic [31:0] w_r;
  logic        w_ge;

  // The bit shifted out of the remainder makes the 33-bit partial remainder >= divisor.
  assign w_r  = {r_hi[30:0], r_lo[31]};
  assign w_ge = r_hi[31] | (w_r >= r_b);
`endif

  assign w_carry = (alu_w < r_hi);

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    alu_req  = (r_state == S_RUN);
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (r_state == S_RUN) begin
`ifdef MULDIV_SEQ_DIV_EN
      if (r_op) begin
        alu_a    = w_r;
        alu_b    = r_b;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a = r_hi;
        alu_b = r_b;
      end
`else
      alu_a = r_hi;
      alu_b = r_b;
`endif
    end
  end

  always_comb begin
    w_nxt_hi = r_lo[0] ? {w_carry, alu_w[31:1]} : {1'b0, r_hi[31:1]};
    w_nxt_lo = {(r_lo[0] ? alu_w[0] : r_hi[0]), r_lo[31:1]};
`ifdef MULDIV_SEQ_DIV_EN
    if (r_op) begin
      w_nxt_hi = w_ge ? alu_w : w_r;
      w_nxt_lo = {r_lo[30:0], w_ge};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULDIV_SEQ_DIV_EN
      r_op    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef MULDIV_SEQ_DIV_EN
            r_op    <= op;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_hi    <= '0;
            r_lo    <= src_a;
            r_b     <= src_b;
            r_cnt   <= '0;
`else
            if (op) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hi    <= '0;
              r_lo    <= '0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_hi    <= '0;
              r_lo    <= src_a;
              r_b     <= src_b;
              r_cnt   <= '0;
            end
`endif
          end
        end
        S_RUN: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; divide cases follow MULDIV_SEQ_DIV_EN.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_w;

  int n_checks = 0;
  int n_pass   = 0;

  int          done_at;
  int          n_busy;
  int          n_done;
  int          n_bad;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always #5 clk = ~clk;

  // Shared ALU seen by the block: add or subtract, same cycle.
  assign alu_w = (alu_ctrl == 4'b0010) ? (alu_a - alu_b) : (alu_a + alu_b);

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_req  (alu_req),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_w    (alu_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one start, then watches 40 cycles; k counts cycles after the accepting edge.
  // With poke set, extra starts land on RUN step 0, RUN step 15 and the DONE cycle.
  task automatic run_op(input logic i_op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int o_done_at, output int o_busy,
                        output int o_done, output int o_bad,
                        output logic [31:0] o_hi, output logic [31:0] o_lo);
    @(negedge clk);
    op    = i_op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    src_a     = 32'hDEAD_BEEF;
    src_b     = 32'h0000_0003;
    o_done_at = -1;
    o_busy    = 0;
    o_done    = 0;
    o_bad     = 0;
    o_hi      = 'x;
    o_lo      = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy === 1'b1) o_busy++;
      if (done === 1'b1) begin
        o_done++;
        if (o_done_at < 0) begin
          o_done_at = k;
          o_hi      = hi;
          o_lo      = lo;
        end
      end
      if (alu_req !== busy) o_bad++;
      if (busy === 1'b1 && i_op == 1'b0 && alu_ctrl !== 4'b0000) o_bad++;
      if (busy === 1'b1 && i_op == 1'b1 && alu_ctrl !== 4'b0010) o_bad++;
      if (busy !== 1'b1 && ({alu_a, alu_b, alu_ctrl} !== 68'd0)) o_bad++;
      if (poke) begin
        op    = 1'b0;
        start = (k == 1 || k == 16 || k == 33);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    src_a = '0;
    src_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_alu", 64'({alu_req, alu_a, alu_b, alu_ctrl}), 64'd0);
    rst = 1'b0;

    // 7 x 6, started on the first edge after reset release.
    run_op(1'b0, 32'd7, 32'd6, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("mul7x6_done_at", 64'(done_at), 64'd33);
    check("mul7x6_busy_cycles", 64'(n_busy), 64'd32);
    check("mul7x6_done_width", 64'(n_done), 64'd1);
    check("mul7x6_alu_ctrl", 64'(n_bad), 64'd0);
    check("mul7x6_result", {r_hi, r_lo}, 64'd42);
    repeat (3) @(negedge clk);
    check("mul7x6_hold", {hi, lo}, 64'd42);

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("mul_max_result", {r_hi, r_lo}, 64'hFFFF_FFFE_0000_0001);
    check("mul_max_done_at", 64'(done_at), 64'd33);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("mul_max_x2", {r_hi, r_lo}, 64'h0000_0001_FFFF_FFFE);

    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("mul_2p16_sq", {r_hi, r_lo}, 64'h0000_0001_0000_0000);

`ifdef MULDIV_SEQ_DIV_EN
    run_op(1'b1, 32'd100, 32'd7, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("div100_7_result", {r_hi, r_lo}, {32'd2, 32'd14});
    check("div100_7_done_at", 64'(done_at), 64'd33);
    check("div100_7_alu_ctrl", 64'(n_bad), 64'd0);

    run_op(1'b1, 32'h8000_0000, 32'd3, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("div_msb_3", {r_hi, r_lo}, {32'd2, 32'h2AAA_AAAA});

    run_op(1'b1, 32'd7, 32'd100, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("div7_100", {r_hi, r_lo}, {32'd7, 32'd0});

    run_op(1'b1, 32'd55, 32'd0, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("div_by_zero_result", {r_hi, r_lo}, {32'd55, 32'hFFFF_FFFF});
    check("div_by_zero_done_at", 64'(done_at), 64'd33);
`else
    run_op(1'b1, 32'd100, 32'd7, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("nodiv_done_at", 64'(done_at), 64'd1);
    check("nodiv_busy_cycles", 64'(n_busy), 64'd0);
    check("nodiv_done_width", 64'(n_done), 64'd1);
    check("nodiv_result", {r_hi, r_lo}, 64'd0);
    check("nodiv_alu_idle", 64'(n_bad), 64'd0);
`endif

    // Reset asserted at RUN step 10 of a multiply, then a fresh 3 x 5.
    @(negedge clk);
    op    = 1'b0;
    src_a = 32'hFFFF_FFFF;
    src_b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("midrun_reset_flags", 64'({busy, done, alu_req}), 64'd0);
    check("midrun_reset_hilo", {hi, lo}, 64'd0);
    check("midrun_reset_alu", 64'({alu_a, alu_b, alu_ctrl}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd3, 32'd5, 1'b0, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("after_reset_mul3x5", {r_hi, r_lo}, 64'd15);
    check("after_reset_done_at", 64'(done_at), 64'd33);

    // Stray starts during RUN and DONE must not disturb the running 7 x 6.
    run_op(1'b0, 32'd7, 32'd6, 1'b1, done_at, n_busy, n_done, n_bad, r_hi, r_lo);
    check("ignore_start_result", {r_hi, r_lo}, 64'd42);
    check("ignore_start_done_at", 64'(done_at), 64'd33);
    check("ignore_start_done_width", 64'(n_done), 64'd1);
    check("ignore_start_busy_cycles", 64'(n_busy), 64'd32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 start  in  1  request a new operation; sampled only in IDLE.
REQ-004 op  in  1  0 = unsigned multiply (MULTU), 1 = unsigned divide (DIVU).
REQ-005 src_a  in  32  multiplicand / dividend.
REQ-006 src_b  in  32  multiplier / divisor.
REQ-007 busy  out  1  high while an operation is in progress; pipeline stall source.
REQ-008 done  out  1  one-cycle pulse when hi/lo become valid.
REQ-009 hi  out  32  MULTU: product[63:32]; DIVU: remainder.
REQ-010 lo  out  32  MULTU: product[31:0]; DIVU: quotient.
REQ-011 alu_req  out  1  high when this block owns the shared ALU; selects its operands at the ALU input mux.
REQ-012 alu_a  out  32  ALU operand i1.
REQ-013 alu_b  out  32  ALU operand i2.
REQ-014 alu_ctrl  out  4  ALU control code: 4'b0000 = add, 4'b0010 = subtract.
REQ-015 alu_w  in  32  ALU result, combinational, same cycle.

Function
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after step 31; DONE->IDLE unconditionally after one cycle.
REQ-017 On start in IDLE, capture operands: MULTU: acc=0, lo=src_a, mcand=src_b; DIVU: rem=0, quot=src_a, divisor=src_b; step counter=0.
REQ-018 busy = (state==RUN); asserted in the first cycle after start is accepted through the last RUN cycle.
REQ-019 done = (state==DONE); exactly one cycle wide.
REQ-020 Latency: start accepted at edge N, done high in cycle N+33, hi/lo valid from that cycle.
REQ-021 alu_req = (state==RUN); when alu_req is 0, alu_a=0, alu_b=0, alu_ctrl=4'b0000.
REQ-022 MULTU step: alu_a=acc, alu_b=mcand, alu_ctrl=add; if lo[0]: carry=(alu_w<acc), {acc,lo}={carry,alu_w,lo}>>1; else {acc,lo}={1'b0,acc,lo}>>1.
REQ-023 DIVU step: {t,r}={rem,quot[31]}, 33 bits; alu_a=r, alu_b=divisor, alu_ctrl=subtract; if t or r>=divisor: rem=alu_w, quot={quot[30:0],1}; else rem=r, quot={quot[30:0],0}.
REQ-024 Results are unsigned, exact, and mod-free: full 64-bit product; quotient/remainder satisfy a = q*b + r, r < b.
REQ-025 Divide by zero: no special path; runs the full 33 cycles and yields lo=32'hFFFFFFFF, hi=src_a.
REQ-026 start while busy or in DONE: ignored; operand inputs don't-care outside the start cycle.
REQ-027 hi/lo hold the last result from DONE until the next accepted start; intermediate values are visible in hi/lo during RUN and are not valid.
REQ-028 Step counter: 5-bit, increments each RUN cycle, wraps at 31->0 on the RUN->DONE transition.

Reset
REQ-029 rst asserted at any time, including mid-operation: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, alu_req=0, alu_a=0, alu_b=0, alu_ctrl=4'b0000; the partial result is discarded.
REQ-030 First start is accepted on the first rising edge with rst low.

Configuration
REQ-031 Macro MULDIV_SEQ_DIV_EN defined: DIVU implemented per REQ-023/REQ-025.
REQ-032 Macro absent: no divide logic; start with op=1 goes IDLE->DONE directly, busy stays 0, done pulses at N+1, hi=lo=0; MULTU unchanged.

Verification
REQ-033 MULTU 7 x 6 -> busy for 32 cycles, done at N+33, hi=0, lo=42, alu_ctrl=4'b0000 throughout RUN.
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
REQ-035 DIVU 100 / 7 (macro defined) -> lo=14, hi=2; DIVU 32'h80000000 / 3 -> lo=32'h2AAAAAAA, hi=2.
REQ-036 DIVU 55 / 0 -> lo=32'hFFFFFFFF, hi=55, done at N+33.
REQ-037 rst pulsed at RUN step 10 -> all outputs 0 asynchronously; a new MULTU 3 x 5 right after gives lo=15 at N+33.
REQ-038 start pulsed at RUN steps 0, 15 and DONE -> ignored, single done pulse, result of the original operands; macro undefined with op=1 -> done at N+1, hi=lo=0, busy never high.
